wb_hdx_uart_fifo: RTL

WB_HDX_UART_FIFO -- requirements
Module: wb_hdx_uart_fifo

---
 rtl/wb_hdx_uart_fifo_if.sv | 31 +++
 rtl/wb_hdx_uart_fifo.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_hdx_uart_fifo_if.sv
// Wishbone slave bus bundle for the half-duplex UART.
// Signal names follow the Wishbone slave's point of view.
interface wb_hdx_uart_fifo_if;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i,
        output wb_dat_i,
        output wb_we_i,
        output wb_stb_i,
        output wb_cyc_i,
        input  wb_dat_o,
        input  wb_ack_o
    );

    modport slave (
        input  wb_adr_i,
        input  wb_dat_i,
        input  wb_we_i,
        input  wb_stb_i,
        input  wb_cyc_i,
        output wb_dat_o,
        output wb_ack_o
    );
endinterface

// File: rtl/wb_hdx_uart_fifo.sv
// Half-duplex 8-N-1 UART with TX/RX FIFOs behind a Wishbone slave.
// The receiver is held idle while the transmitter drives the line.
module wb_hdx_uart_fifo #(
    parameter int CLK_FREQ_HZ  = 72_000_000,
    parameter int DEFAULT_BAUD = 19_200,
    parameter int FIFO_DEPTH   = 16,
    parameter int GUARD_BITS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_hdx_uart_fifo_if.slave wb,
    output logic              tx_out,
    input  logic              rx_in,
    output logic              tx_active
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);
    localparam int DIV_RAW = CLK_FREQ_HZ / DEFAULT_BAUD;
    localparam logic [15:0] DIV_RST =
        (DIV_RAW < 16) ? 16'd16 : 16'(DIV_RAW);
    localparam bit GB_NONE = (GUARD_BITS == 0);
    localparam logic [7:0] GB_LAST =
        GB_NONE ? 8'd0 : 8'(GUARD_BITS - 1);

    localparam logic [2:0] TX_IDLE  = 3'd0;
    localparam logic [2:0] TX_START = 3'd1;
    localparam logic [2:0] TX_DATA  = 3'd2;
    localparam logic [2:0] TX_STOP  = 3'd3;
    localparam logic [2:0] TX_GUARD = 3'd4;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic          r_ack;
    logic [15:0]   r_baud;
    logic          r_ovr;
    logic          r_ferr;
    logic          r_txovf;

    logic [7:0]    r_txm [FIFO_DEPTH];
    logic [AW-1:0] r_txw;
    logic [AW-1:0] r_txr;
    logic [CW-1:0] r_txc;

    logic [7:0]    r_rxm [FIFO_DEPTH];
    logic [AW-1:0] r_rxw;
    logic [AW-1:0] r_rxr;
    logic [CW-1:0] r_rxc;

    logic [2:0]    r_tx_st;
    logic [15:0]   r_tx_cnt;
    logic [15:0]   r_tx_div;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_gcnt;
    logic [7:0]    r_tx_sh;
    logic          r_tx_out;
    logic          r_tx_act;

    logic          r_rx_s1;
    logic          r_rx_s2;
    logic [1:0]    r_rx_st;
    logic [15:0]   r_rx_cnt;
    logic [15:0]   r_rx_div;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_sh;

    logic          w_req;
    logic          w_wr;
    logic          w_rd;
    logic [1:0]    w_sel;
    logic          w_st_wr;
    logic          w_tx_full;
    logic          w_tx_emp;
    logic          w_tx_wr;
    logic          w_tx_push;
    logic          w_tx_pop;
    logic          w_tx_tick;
    logic [7:0]    w_tx_head;
    logic          w_rx_full;
    logic          w_rx_emp;
    logic          w_rx_push;
    logic          w_rx_pop;
    logic          w_rx_done;
    logic          w_rx_ferr;
    logic          w_rx_drop;
    logic          w_rx_tick;
    logic [15:0]   w_rx_half;
    logic [7:0]    w_rx_head;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;

    assign w_req   = wb.wb_stb_i & wb.wb_cyc_i & ~r_ack;
    assign w_wr    = w_req & wb.wb_we_i;
    assign w_rd    = w_req & ~wb.wb_we_i;
    assign w_sel   = wb.wb_adr_i[3:2];
    assign w_st_wr = w_wr & (w_sel == 2'd1);

    assign w_tx_full = (r_txc == FULL_C);
    assign w_tx_emp  = (r_txc == '0);
    assign w_tx_wr   = w_wr & (w_sel == 2'd0);
    assign w_tx_push = w_tx_wr & ~w_tx_full;
    assign w_tx_head = r_txm[r_txr];
    assign w_tx_tick = (r_tx_cnt == r_tx_div - 16'd1);
    assign w_tx_pop  = ~w_tx_emp &
        ((r_tx_st == TX_IDLE) | ((r_tx_st == TX_STOP) & w_tx_tick));

    assign w_rx_full = (r_rxc == FULL_C);
    assign w_rx_emp  = (r_rxc == '0);
    assign w_rx_head = r_rxm[r_rxr];
    assign w_rx_pop  = w_rd & (w_sel == 2'd2) & ~w_rx_emp;
    assign w_rx_tick = (r_rx_cnt == r_rx_div - 16'd1);
    assign w_rx_half = {1'b0, r_rx_div[15:1]} - 16'd1;
    assign w_rx_done = (r_rx_st == RX_STOP) & w_rx_tick & r_rx_s2;
    assign w_rx_ferr = (r_rx_st == RX_STOP) & w_rx_tick & ~r_rx_s2;
    // A full FIFO still accepts a byte when a pop frees a slot this cycle.
    assign w_rx_push = w_rx_done & (~w_rx_full | w_rx_pop);
    assign w_rx_drop = w_rx_done & w_rx_full & ~w_rx_pop;

    assign w_status = {8'd0, 8'(r_txc), 8'(r_rxc), 1'b0,
                       r_txovf, r_ferr, r_ovr,
                       w_tx_emp & (r_tx_st == TX_IDLE),
                       r_tx_act, ~w_rx_emp, ~w_tx_full};

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            2'd1: w_rdata = w_status;
            2'd2: if (!w_rx_emp) w_rdata = {23'd0, 1'b1, w_rx_head};
            2'd3: w_rdata = {16'd0, r_baud};
            default: w_rdata = '0;
        endcase
    end

    assign wb.wb_dat_o = w_rdata;
    assign wb.wb_ack_o = r_ack;
    assign tx_out      = r_tx_out;
    assign tx_active   = r_tx_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack   <= 1'b0;
            r_baud  <= DIV_RST;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
            r_txovf <= 1'b0;
        end else begin
            r_ack   <= w_req;
            r_ovr   <= w_rx_drop |
                       (r_ovr & ~(w_st_wr & wb.wb_dat_i[4]));
            r_ferr  <= w_rx_ferr |
                       (r_ferr & ~(w_st_wr & wb.wb_dat_i[5]));
            r_txovf <= (w_tx_wr & w_tx_full) |
                       (r_txovf & ~(w_st_wr & wb.wb_dat_i[6]));
            if (w_wr && w_sel == 2'd3)
                r_baud <= (wb.wb_dat_i[15:0] < 16'd16) ?
                          16'd16 : wb.wb_dat_i[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_txm[r_txw] <= wb.wb_dat_i[7:0];
        if (w_rx_push) r_rxm[r_rxw] <= r_rx_sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txw <= '0;
            r_txr <= '0;
            r_txc <= '0;
            r_rxw <= '0;
            r_rxr <= '0;
            r_rxc <= '0;
        end else begin
            if (w_tx_push) r_txw <= r_txw + 1'b1;
            if (w_tx_pop)  r_txr <= r_txr + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_txc <= r_txc + 1'b1;
                2'b01:   r_txc <= r_txc - 1'b1;
                default: r_txc <= r_txc;
            endcase
            if (w_rx_push) r_rxw <= r_rxw + 1'b1;
            if (w_rx_pop)  r_rxr <= r_rxr + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rxc <= r_rxc + 1'b1;
                2'b01:   r_rxc <= r_rxc - 1'b1;
                default: r_rxc <= r_rxc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_st   <= TX_IDLE;
            r_tx_cnt  <= '0;
            r_tx_div  <= DIV_RST;
            r_tx_bit  <= '0;
            r_tx_gcnt <= '0;
            r_tx_sh   <= '0;
            r_tx_out  <= 1'b1;
            r_tx_act  <= 1'b0;
        end else begin
            unique case (r_tx_st)
                TX_IDLE: begin
                    if (!w_tx_emp) begin
                        r_tx_sh  <= w_tx_head;
                        r_tx_div <= r_baud;
                        r_tx_cnt <= '0;
                        r_tx_out <= 1'b0;
                        r_tx_act <= 1'b1;
                        r_tx_st  <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= '0;
                        r_tx_bit <= '0;
                        r_tx_out <= r_tx_sh[0];
                        r_tx_st  <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_out <= 1'b1;
                            r_tx_st  <= TX_STOP;
                        end else begin
                            r_tx_bit <= r_tx_bit + 3'd1;
                            r_tx_sh  <= r_tx_sh >> 1;
                            r_tx_out <= r_tx_sh[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= '0;
                        // Back-to-back frames skip the guard entirely.
                        if (!w_tx_emp) begin
                            r_tx_sh  <= w_tx_head;
                            r_tx_div <= r_baud;
                            r_tx_out <= 1'b0;
                            r_tx_st  <= TX_START;
                        end else if (GB_NONE) begin
                            r_tx_act <= 1'b0;
                            r_tx_st  <= TX_IDLE;
                        end else begin
                            r_tx_gcnt <= '0;
                            r_tx_st   <= TX_GUARD;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                TX_GUARD: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= '0;
                        if (r_tx_gcnt == GB_LAST) begin
                            r_tx_act <= 1'b0;
                            r_tx_st  <= TX_IDLE;
                        end else begin
                            r_tx_gcnt <= r_tx_gcnt + 8'd1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                default: begin
                    r_tx_out <= 1'b1;
                    r_tx_act <= 1'b0;
                    r_tx_st  <= TX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1  <= 1'b1;
            r_rx_s2  <= 1'b1;
            r_rx_st  <= RX_IDLE;
            r_rx_cnt <= '0;
            r_rx_div <= DIV_RST;
            r_rx_bit <= '0;
            r_rx_sh  <= '0;
        end else begin
            r_rx_s1 <= rx_in;
            r_rx_s2 <= r_rx_s1;
            unique case (r_rx_st)
                RX_IDLE: begin
                    if (!r_tx_act && !r_rx_s2) begin
                        r_rx_div <= r_baud;
                        r_rx_cnt <= '0;
                        r_rx_st  <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == w_rx_half) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_st  <= r_rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_cnt <= '0;
                        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                        if (r_rx_bit == 3'd7) r_rx_st <= RX_STOP;
                        else r_rx_bit <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (w_rx_tick) begin
                        r_rx_cnt <= '0;
                        r_rx_st  <= RX_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                default: r_rx_st <= RX_IDLE;
            endcase
        end
    end

endmodule
